parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

Receive-side companion to `parity_bit_gen`. It consumes a serial frame of `NUM_BITS` data bits followed by one parity bit, all qualified by `wr_en`, as produced by the `shift_reg` / `parity_bit_gen` pair. It reassembles the data word, checks the parity bit, and flags mismatches. It also keeps a saturating error count and resynchronises after stalled frames.

## Interface
Parameters:
- `NUM_BITS`, 4 — data bits per frame; legal range 1–32.
- `EVEN_PARITY_BIT`, 0 — same meaning as in `parity_bit_gen`. Expected parity = (^word) ^ `EVEN_PARITY_BIT`.
- `GAP_TIMEOUT`, 16 — maximum idle cycles between `wr_en` pulses inside a frame before the frame is aborted. 0 disables the timeout.
- `ERR_CNT_WIDTH`, 8 — width of the error counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clr`  in  1  synchronous clear of the frame state and error counter.
- `data_in`  in  1  serial bit; sampled only when `wr_en`=1.
- `wr_en`  in  1  bit-valid strobe; one bit per cycle when high.
- `data_out`  out  `NUM_BITS`  last completed data word.
- `data_valid`  out  1  one-cycle pulse when a frame completes.
- `parity_err`  out  1  one-cycle pulse, coincident with `data_valid`, on parity mismatch.
- `frame_abort`  out  1  one-cycle pulse when a frame is dropped on gap timeout.
- `err_count`  out  `ERR_CNT_WIDTH`  saturating count of parity errors.

## Operation
- FSM states:
  - `DATA`: collect data bits.
  - `PAR`: await the parity bit.
  - Reset state is `DATA`, with `bit_cnt`=0.
- `DATA`, on each `wr_en`:
  - Shift `data_in` into the word register, MSB first. The first bit received lands in `data_out[NUM_BITS-1]`.
  - Running parity ^= `data_in`; `bit_cnt`++.
  - When the `NUM_BITS`-th bit is accepted, go to `PAR`.
- `PAR`, on `wr_en`:
  - Compare `data_in` against running parity ^ `EVEN_PARITY_BIT`.
  - Load `data_out`, pulse `data_valid`, and pulse `parity_err` if they differ.
  - Return to `DATA` with `bit_cnt` and running parity cleared.
- `err_count` increments on every `parity_err` pulse. It saturates at all-ones and never wraps.
- Gap timer:
  - Counts cycles with `wr_en`=0 while mid-frame (`bit_cnt`>0, or state is `PAR`). It is cleared by any `wr_en`.
  - When it reaches `GAP_TIMEOUT`, pulse `frame_abort`, discard the partial frame, and return to `DATA`.
  - The timer does not run while idle at a frame boundary.
- `data_out` changes only on frame completion. It holds its value across aborts and gaps.
- `clr` (highest priority after reset):
  - Returns the FSM to `DATA` and clears `bit_cnt`, the gap timer and `err_count`.
  - Suppresses `data_valid`, `parity_err` and `frame_abort` that cycle.
  - The `data_in` bit sampled in that cycle is discarded.
  - `data_out` is unchanged.
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_abort`=0, `err_count`=0.
- Reset mid-frame drops the partial frame with no pulse.

## Timing
- All outputs are registered. `data_valid`/`parity_err` assert in the cycle after the edge that samples the parity bit, and are high for exactly one cycle.
- Back-to-back frames (`wr_en` held high) are supported with no dead cycle. The first data bit of the next frame may be sampled on the cycle immediately after the parity bit.
- Gaps in `wr_en` shorter than `GAP_TIMEOUT` cycles are tolerated anywhere in a frame.
- `frame_abort` asserts the cycle after the `GAP_TIMEOUT`-th consecutive idle cycle.
- If `wr_en` arrives on the same edge the timeout would fire, the bit wins and no abort occurs.
- Saturated `err_count` plus a new error: `parity_err` still pulses and the count holds.

## Test plan
- `NUM_BITS`=4, `EVEN_PARITY_BIT`=0. Send bits 1,0,0,1, then parity 0 → `data_out`=4'b1001, one `data_valid` pulse, `parity_err`=0, `err_count`=0.
- Same word 1001, parity bit 1 → `data_valid` and `parity_err` pulse together, `err_count`=1.
- Run with `EVEN_PARITY_BIT`=1. Send word 1011, parity 0 → no error. Send the same word with parity 1 → error.
- Three back-to-back frames with `wr_en` continuously high: 1001/0, 0111/1, 0000/1 → three `data_valid` pulses, one error (third frame), `err_count`=1.
- Send 2 data bits, then `wr_en` low for 16 cycles → `frame_abort` pulse, `data_out` unchanged. The next full frame 1100/0 decodes correctly.
- `ERR_CNT_WIDTH`=2: five bad frames → `err_count` sequence 1,2,3,3,3.
- Assert `clr` mid-frame after 3 bits → no pulse and `err_count`=0. A following full frame decodes correctly.
- Deassert `rst_n` mid-frame after 3 bits → no pulse and all outputs at reset values. A following full frame decodes correctly.

Source files
------------

// File: rtl/parity_frame_checker.sv
// -----------------------------------------------------------------------------
// parity_frame_checker
//
// Receive-side frame checker for a serial stream of NUM_BITS data bits followed
// by one parity bit, every bit qualified by wr_en. It rebuilds the data word
// (MSB first), compares the received parity bit with the running parity of the
// word, keeps a saturating error count and drops frames that stall.
//
// Parameters
//   NUM_BITS        data bits per frame (1..32)
//   EVEN_PARITY_BIT expected parity = (^word) ^ EVEN_PARITY_BIT
//   GAP_TIMEOUT     idle cycles tolerated inside a frame; 0 disables the timer
//   ERR_CNT_WIDTH   width of the saturating parity error counter
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear of frame state and error counter
//   data_in     in   serial bit, sampled when wr_en=1
//   wr_en       in   bit-valid strobe
//   data_out    out  last completed data word
//   data_valid  out  one-cycle pulse when a frame completes
//   parity_err  out  one-cycle pulse with data_valid on parity mismatch
//   frame_abort out  one-cycle pulse when a frame is dropped on gap timeout
//   err_count   out  saturating count of parity errors
// -----------------------------------------------------------------------------
module parity_frame_checker #(
    parameter int NUM_BITS        = 4,
    parameter bit EVEN_PARITY_BIT = 1'b0,
    parameter int GAP_TIMEOUT     = 16,
    parameter int ERR_CNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     data_in,
    input  logic                     wr_en,
    output logic [NUM_BITS-1:0]      data_out,
    output logic                     data_valid,
    output logic                     parity_err,
    output logic                     frame_abort,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    // The bit counter only needs to reach NUM_BITS-1: the parity phase is
    // tracked by the state itself, so the counter is cleared on entry to PAR.
    localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TIMEOUT > 0) ? GAP_W'(GAP_TIMEOUT - 1) : '0;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_PAR  = 1'b1
    } state_t;

    // State registers and their next values
    state_t                     r_state, r_state_next;
    logic [CNT_W-1:0]           r_bit_cnt, r_bit_cnt_next;
    logic [NUM_BITS-1:0]        r_word, r_word_next;
    logic                       r_par, r_par_next;
    logic [GAP_W-1:0]           r_gap, r_gap_next;
    logic [NUM_BITS-1:0]        r_data_out, r_data_out_next;
    logic                       r_valid, r_valid_next;
    logic                       r_perr, r_perr_next;
    logic                       r_abort, r_abort_next;
    logic [ERR_CNT_WIDTH-1:0]   r_err_cnt, r_err_cnt_next;

    logic [NUM_BITS-1:0]        w_word_shifted;
    logic                       w_mid_frame;
    logic                       w_par_mismatch;

    // MSB-first shift: the oldest bit walks up towards NUM_BITS-1, so after
    // NUM_BITS shifts the first received bit sits in the MSB.
    assign w_word_shifted[0] = data_in;
    generate
        for (genvar gi = 1; gi < NUM_BITS; gi++) begin : g_shift
            assign w_word_shifted[gi] = r_word[gi-1];
        end
    endgenerate

    // A frame is in progress once any data bit has been taken, or while
    // waiting for the parity bit.
    assign w_mid_frame    = (r_state == ST_PAR) || (r_bit_cnt != '0);
    assign w_par_mismatch = data_in ^ r_par ^ EVEN_PARITY_BIT;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_DATA;
            r_bit_cnt  <= '0;
            r_word     <= '0;
            r_par      <= 1'b0;
            r_gap      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_abort    <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= r_state_next;
            r_bit_cnt  <= r_bit_cnt_next;
            r_word     <= r_word_next;
            r_par      <= r_par_next;
            r_gap      <= r_gap_next;
            r_data_out <= r_data_out_next;
            r_valid    <= r_valid_next;
            r_perr     <= r_perr_next;
            r_abort    <= r_abort_next;
            r_err_cnt  <= r_err_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        r_state_next    = r_state;
        r_bit_cnt_next  = r_bit_cnt;
        r_word_next     = r_word;
        r_par_next      = r_par;
        r_gap_next      = r_gap;
        r_data_out_next = r_data_out;
        r_err_cnt_next  = r_err_cnt;
        // Status outputs are pulses: low unless an event fires this cycle.
        r_valid_next    = 1'b0;
        r_perr_next     = 1'b0;
        r_abort_next    = 1'b0;

        if (clr) begin
            // Any bit presented alongside clr is dropped; data_out is kept.
            r_state_next   = ST_DATA;
            r_bit_cnt_next = '0;
            r_par_next     = 1'b0;
            r_gap_next     = '0;
            r_err_cnt_next = '0;
        end else if (wr_en) begin
            // A bit always wins over a timeout due on the same edge.
            r_gap_next = '0;
            case (r_state)
                ST_DATA: begin
                    r_word_next = w_word_shifted;
                    r_par_next  = r_par ^ data_in;
                    if (r_bit_cnt == CNT_LAST) begin
                        r_state_next   = ST_PAR;
                        r_bit_cnt_next = '0;
                    end else begin
                        r_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    end
                end
                ST_PAR: begin
                    r_data_out_next = r_word;
                    r_valid_next    = 1'b1;
                    r_perr_next     = w_par_mismatch;
                    if (w_par_mismatch && (r_err_cnt != ERR_MAX)) begin
                        r_err_cnt_next = r_err_cnt + ERR_CNT_WIDTH'(1);
                    end
                    r_state_next   = ST_DATA;
                    r_bit_cnt_next = '0;
                    r_par_next     = 1'b0;
                end
                default: begin
                    r_state_next   = ST_DATA;
                    r_bit_cnt_next = '0;
                    r_par_next     = 1'b0;
                end
            endcase
        end else if (w_mid_frame && (GAP_TIMEOUT != 0)) begin
            // r_gap holds the number of idle cycles already seen, so the
            // GAP_TIMEOUT-th idle cycle is the one where it equals GAP_LAST.
            if (r_gap == GAP_LAST) begin
                r_abort_next   = 1'b1;
                r_state_next   = ST_DATA;
                r_bit_cnt_next = '0;
                r_par_next     = 1'b0;
                r_gap_next     = '0;
            end else begin
                r_gap_next = r_gap + GAP_W'(1);
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_valid;
    assign parity_err  = r_perr;
    assign frame_abort = r_abort;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_parity_frame_checker.sv
// -----------------------------------------------------------------------------
// Testbench for parity_frame_checker. Three instances share the same stimulus:
//   A: odd-style default (EVEN_PARITY_BIT=0), 8-bit error counter
//   B: EVEN_PARITY_BIT=1
//   C: EVEN_PARITY_BIT=0, 2-bit error counter (saturation)
// Inputs change on the falling edge; outputs are snapshotted on the falling
// edge just before each new input is applied.
// -----------------------------------------------------------------------------
module tb_parity_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clr, data_in, wr_en;

    logic [3:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_perr, b_perr, c_perr;
    logic       a_abort, b_abort, c_abort;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    parity_frame_checker #(.NUM_BITS(4), .EVEN_PARITY_BIT(1'b0), .GAP_TIMEOUT(16), .ERR_CNT_WIDTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(data_in), .wr_en(wr_en),
        .data_out(a_data), .data_valid(a_valid), .parity_err(a_perr),
        .frame_abort(a_abort), .err_count(a_cnt));

    parity_frame_checker #(.NUM_BITS(4), .EVEN_PARITY_BIT(1'b1), .GAP_TIMEOUT(16), .ERR_CNT_WIDTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(data_in), .wr_en(wr_en),
        .data_out(b_data), .data_valid(b_valid), .parity_err(b_perr),
        .frame_abort(b_abort), .err_count(b_cnt));

    parity_frame_checker #(.NUM_BITS(4), .EVEN_PARITY_BIT(1'b0), .GAP_TIMEOUT(16), .ERR_CNT_WIDTH(2)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(data_in), .wr_en(wr_en),
        .data_out(c_data), .data_valid(c_valid), .parity_err(c_perr),
        .frame_abort(c_abort), .err_count(c_cnt));

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Snapshot of outputs and running pulse tallies for instance A
    logic [3:0] s_a_data;
    logic       s_a_valid, s_a_perr, s_a_abort, s_b_valid, s_b_perr, s_c_perr;
    logic [7:0] s_a_cnt, s_b_cnt;
    logic [1:0] s_c_cnt;
    int t_valid_a, t_err_a, t_abort_a;

    typedef struct {
        logic [3:0] word;
        logic       par;
        logic       err_a;
        logic [7:0] cnt_a;
        logic       err_b;
        logic [7:0] cnt_b;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic snap();
        s_a_data  = a_data;
        s_a_valid = a_valid;
        s_a_perr  = a_perr;
        s_a_abort = a_abort;
        s_a_cnt   = a_cnt;
        s_b_valid = b_valid;
        s_b_perr  = b_perr;
        s_b_cnt   = b_cnt;
        s_c_perr  = c_perr;
        s_c_cnt   = c_cnt;
        t_valid_a += int'(a_valid);
        t_err_a   += int'(a_perr);
        t_abort_a += int'(a_abort);
    endtask

    task automatic clear_tally();
        t_valid_a = 0;
        t_err_a   = 0;
        t_abort_a = 0;
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        snap();
        data_in = b;
        wr_en   = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        snap();
        data_in = 1'b0;
        wr_en   = 1'b0;
    endtask

    // Sends word (MSB first) and parity, then one idle cycle whose snapshot
    // shows the completion pulse.
    task automatic send_frame(input logic [3:0] w, input logic p);
        for (int i = 3; i >= 0; i--) drive_bit(w[i]);
        drive_bit(p);
        idle();
    endtask

    task automatic do_clr();
        @(negedge clk);
        snap();
        clr   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        snap();
        clr = 1'b0;
    endtask

    initial begin
        logic [14:0] bb;
        logic [1:0]  exp_c;

        vecs[0] = '{word: 4'b1001, par: 1'b0, err_a: 1'b0, cnt_a: 8'd0, err_b: 1'b1, cnt_b: 8'd1};
        vecs[1] = '{word: 4'b1001, par: 1'b1, err_a: 1'b1, cnt_a: 8'd1, err_b: 1'b0, cnt_b: 8'd1};
        vecs[2] = '{word: 4'b1011, par: 1'b0, err_a: 1'b1, cnt_a: 8'd2, err_b: 1'b0, cnt_b: 8'd1};
        vecs[3] = '{word: 4'b1011, par: 1'b1, err_a: 1'b0, cnt_a: 8'd2, err_b: 1'b1, cnt_b: 8'd2};

        rst_n = 1'b0; clr = 1'b0; data_in = 1'b0; wr_en = 1'b0;
        clear_tally();
        repeat (2) @(negedge clk);
        check("reset_data",  a_data, 4'h0);
        check("reset_valid", a_valid, 1'b0);
        check("reset_perr",  a_perr, 1'b0);
        check("reset_abort", a_abort, 1'b0);
        check("reset_cnt",   a_cnt, 8'd0);
        rst_n = 1'b1;

        // Table-driven single frames, odd and even parity instances together
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].word, vecs[v].par);
            $display("frame %0d word=%b par=%b valid=%b err_a=%b cnt_a=%0d err_b=%b cnt_b=%0d",
                     v, vecs[v].word, vecs[v].par, s_a_valid, s_a_perr, s_a_cnt, s_b_perr, s_b_cnt);
            check("vec_valid_a", s_a_valid, 1'b1);
            check("vec_valid_b", s_b_valid, 1'b1);
            check("vec_data_a",  s_a_data, vecs[v].word);
            check("vec_err_a",   s_a_perr, vecs[v].err_a);
            check("vec_err_b",   s_b_perr, vecs[v].err_b);
            check("vec_cnt_a",   s_a_cnt, vecs[v].cnt_a);
            check("vec_cnt_b",   s_b_cnt, vecs[v].cnt_b);
            idle();
            check("vec_valid_one_cycle", s_a_valid, 1'b0);
            check("vec_err_one_cycle",   s_a_perr, 1'b0);
        end

        // Back-to-back frames, wr_en never drops: 1001/0, 0111/1, 0000/1
        do_clr();
        check("clr_cnt", s_a_cnt, 8'd0);
        clear_tally();
        bb = {4'b1001, 1'b0, 4'b0111, 1'b1, 4'b0000, 1'b1};
        for (int k = 0; k < 15; k++) begin
            drive_bit(bb[14-k]);
            if (k == 5) begin
                check("b2b_f1_data", s_a_data, 4'b1001);
                check("b2b_f1_err",  s_a_perr, 1'b0);
            end
            if (k == 10) begin
                check("b2b_f2_data", s_a_data, 4'b0111);
                check("b2b_f2_err",  s_a_perr, 1'b0);
            end
        end
        idle();
        $display("b2b valid_pulses=%0d err_pulses=%0d cnt=%0d data=%b", t_valid_a, t_err_a, s_a_cnt, s_a_data);
        check("b2b_f3_err",   s_a_perr, 1'b1);
        check("b2b_f3_data",  s_a_data, 4'b0000);
        check("b2b_valids",   t_valid_a, 3);
        check("b2b_errs",     t_err_a, 1);
        check("b2b_cnt",      s_a_cnt, 8'd1);

        // Gap handling: a 15-cycle gap is tolerated, a 16-cycle gap aborts
        do_clr();
        send_frame(4'b1001, 1'b0);
        clear_tally();
        drive_bit(1'b1);
        drive_bit(1'b1);
        repeat (15) idle();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle();
        $display("gap15 valid=%b data=%b err=%b aborts=%0d", s_a_valid, s_a_data, s_a_perr, t_abort_a);
        check("gap15_valid", s_a_valid, 1'b1);
        check("gap15_data",  s_a_data, 4'b1100);
        check("gap15_err",   s_a_perr, 1'b0);
        check("gap15_noabort", t_abort_a, 0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (16) idle();
        check("gap16_early_abort", t_abort_a, 0);
        idle();
        $display("gap16 abort=%b data=%b", s_a_abort, s_a_data);
        check("gap16_abort",      s_a_abort, 1'b1);
        check("gap16_data_held",  s_a_data, 4'b1100);
        idle();
        check("gap16_abort_one_cycle", s_a_abort, 1'b0);
        clear_tally();
        send_frame(4'b0110, 1'b0);
        $display("post_abort valid=%b data=%b err=%b", s_a_valid, s_a_data, s_a_perr);
        check("post_abort_valid", s_a_valid, 1'b1);
        check("post_abort_data",  s_a_data, 4'b0110);
        check("post_abort_err",   s_a_perr, 1'b0);
        clear_tally();
        repeat (20) idle();
        check("boundary_idle_noabort", t_abort_a, 0);

        // Saturation of the 2-bit counter: 1,2,3,3,3
        do_clr();
        for (int n = 0; n < 5; n++) begin
            send_frame(4'b1001, 1'b1);
            exp_c = (n < 3) ? 2'(n + 1) : 2'd3;
            $display("sat frame %0d err_c=%b cnt_c=%0d", n, s_c_perr, s_c_cnt);
            check("sat_err_c", s_c_perr, 1'b1);
            check("sat_cnt_c", s_c_cnt, exp_c);
        end
        check("sat_cnt_a", s_a_cnt, 8'd5);

        // clr after 3 bits, with a bit presented in the clr cycle
        clear_tally();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk);
        snap();
        clr = 1'b1; wr_en = 1'b1; data_in = 1'b1;
        @(negedge clk);
        snap();
        clr = 1'b0; wr_en = 1'b0; data_in = 1'b0;
        idle();
        $display("clr mid-frame valids=%0d aborts=%0d cnt_a=%0d cnt_c=%0d", t_valid_a, t_abort_a, s_a_cnt, s_c_cnt);
        check("clr_no_valid",   t_valid_a, 0);
        check("clr_no_abort",   t_abort_a, 0);
        check("clr_cnt_a",      s_a_cnt, 8'd0);
        check("clr_cnt_c",      s_c_cnt, 2'd0);
        check("clr_data_held",  s_a_data, 4'b1001);
        send_frame(4'b0101, 1'b0);
        check("post_clr_valid", s_a_valid, 1'b1);
        check("post_clr_data",  s_a_data, 4'b0101);
        check("post_clr_err",   s_a_perr, 1'b0);

        // Reset after 3 bits
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; data_in = 1'b0;
        #1;
        $display("reset mid-frame data=%b valid=%b cnt=%0d", a_data, a_valid, a_cnt);
        check("rst_mid_data",  a_data, 4'h0);
        check("rst_mid_valid", a_valid, 1'b0);
        check("rst_mid_abort", a_abort, 1'b0);
        check("rst_mid_cnt",   a_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_tally();
        send_frame(4'b0011, 1'b0);
        $display("post_reset valid=%b data=%b err=%b", s_a_valid, s_a_data, s_a_perr);
        check("post_rst_valid",  s_a_valid, 1'b1);
        check("post_rst_data",   s_a_data, 4'b0011);
        check("post_rst_err",    s_a_perr, 1'b0);
        check("post_rst_pulses", t_valid_a, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
